// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter.
// Merges the non-stallable pipeline writeback with a buffered secondary result
// stream (divider / load-miss). The pipeline always wins the port. Buffered
// results to the same register are squashed so an older value never lands on
// top of a newer one. Pending destinations are exposed for hazard detection.
module rf_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     p_valid,
  input  logic [4:0]               p_rd,
  input  logic [31:0]              p_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [4:0]               s_rd,
  input  logic [31:0]              s_data,
  output logic                     we,
  output logic [4:0]               wa,
  output logic [31:0]              wd,
  input  logic [4:0]               q_a1,
  input  logic [4:0]               q_a2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT - 1);

  logic [4:0]       ent_rd   [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [DEPTH-1:0] ent_live;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          out_sec;

  logic prim_sel;
  logic push;
  logic pop;
  logic push_live;
  logic hit1;
  logic hit2;

  // Port selection: primary owns the port; FIFO head pops only on free cycles.
  // Ready is decided on the pre-pop occupancy so a pop never frees a slot early.
  always_comb begin
    prim_sel  = p_valid && (p_rd != 5'd0);
    s_ready   = (count != CNT_FULL);
    push      = s_valid && s_ready && (s_rd != 5'd0);
    pop       = !prim_sel && (count != '0);
    push_live = !(prim_sel && (s_rd == p_rd));
  end

  // Payload storage; only written on enqueue, validity is carried by ent_live.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_rd[wr_ptr]   <= s_rd;
      ent_data[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers, occupancy and live bits, including WAW squash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      ent_live <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (prim_sel && (ent_rd[i] == p_rd))
          ent_live[i] <= 1'b0;
      end
      // A popped slot is cleared so stale entries never look pending.
      if (pop) begin
        ent_live[rd_ptr] <= 1'b0;
        rd_ptr           <= rd_ptr + PTR_ONE;
      end
      // Same-cycle primary write to the same rd makes the new entry dead on arrival.
      if (push) begin
        ent_live[wr_ptr] <= push_live;
        wr_ptr           <= wr_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Registered write port; dead entries still pop but with the enable low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we      <= 1'b0;
      wa      <= '0;
      wd      <= '0;
      out_sec <= 1'b0;
    end else if (prim_sel) begin
      we      <= 1'b1;
      wa      <= p_rd;
      wd      <= p_data;
      out_sec <= 1'b0;
    end else if (pop) begin
      we      <= ent_live[rd_ptr];
      wa      <= ent_rd[rd_ptr];
      wd      <= ent_data[rd_ptr];
      out_sec <= 1'b1;
    end else begin
      we      <= 1'b0;
    end
  end

  // Head-starvation timer; saturates at the limit so stall_req holds until a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else if ((count == '0) || pop) begin
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      stall_req <= (starve_cnt == STARVE_MAX);
      if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + STARVE_ONE;
    end
  end

  // Pending-write scoreboard: live FIFO entries plus a secondary write in flight.
  always_comb begin
    hit1 = we && out_sec && (wa == q_a1);
    hit2 = we && out_sec && (wa == q_a2);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live[i] && (ent_rd[i] == q_a1)) hit1 = 1'b1;
      if (ent_live[i] && (ent_rd[i] == q_a2)) hit2 = 1'b1;
    end
    busy1 = (q_a1 != 5'd0) && hit1;
    busy2 = (q_a2 != 5'd0) && hit2;
  end

  assign fifo_count = count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: hand-derived vector table, directed full/stall
// and async-reset sequences, then randomized traffic against a queue model.
module tb_rf_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        s_valid;
  logic        s_ready;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  q_a1;
  logic [4:0]  q_a2;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic [$clog2(DEPTH):0] fifo_count;

  rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_rd(s_rd), .s_data(s_data),
    .we(we), .wa(wa), .wd(wd),
    .q_a1(q_a1), .q_a2(q_a2), .busy1(busy1), .busy2(busy2),
    .stall_req(stall_req), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending results plus the write-port register.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_sec;
  bit          m_stall;
  int          m_wait;

  task automatic model_reset();
    mq.delete();
    m_we = 0; m_wa = '0; m_wd = '0; m_sec = 0; m_stall = 0; m_wait = 0;
  endtask

  function automatic bit m_busy(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == q) return 1'b1;
    return m_we && m_sec && (m_wa == q);
  endfunction

  task automatic apply(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit sv, input logic [4:0] srd, input logic [31:0] sd,
                       input logic [4:0] q1, input logic [4:0] q2);
    p_valid = pv; p_rd = prd; p_data = pd;
    s_valid = sv; s_rd = srd; s_data = sd;
    q_a1 = q1; q_a2 = q2;
    #1;
    check("m_we", 32'(we), 32'(m_we));
    check("m_wa", 32'(wa), 32'(m_wa));
    check("m_wd", wd, m_wd);
    check("m_s_ready", 32'(s_ready), 32'(mq.size() < DEPTH));
    check("m_busy1", 32'(busy1), 32'(m_busy(q1)));
    check("m_busy2", 32'(busy2), 32'(m_busy(q2)));
    check("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("m_stall_req", 32'(stall_req), 32'(m_stall));
  endtask

  // Advance the model by one clock using the currently driven inputs, then clock the DUT.
  task automatic advance();
    bit   prim;
    bit   pop;
    int   sz;
    ent_t head;
    prim = p_valid && (p_rd != 5'd0);
    sz   = mq.size();
    pop  = !prim && (sz > 0);
    if (prim) foreach (mq[i]) if (mq[i].rd == p_rd) mq[i].live = 1'b0;
    if (pop) head = mq.pop_front();
    if (s_valid && (sz < DEPTH) && (s_rd != 5'd0))
      mq.push_back('{rd: s_rd, data: s_data, live: !(prim && (s_rd == p_rd))});
    if (prim) begin
      m_we = 1; m_wa = p_rd; m_wd = p_data; m_sec = 0;
    end else if (pop) begin
      m_we = head.live; m_wa = head.rd; m_wd = head.data; m_sec = 1;
    end else begin
      m_we = 0;
    end
    if (sz == 0 || pop) begin
      m_wait = 0; m_stall = 0;
    end else begin
      m_stall = (m_wait >= LIMIT - 1);
      m_wait++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit pv; logic [4:0] prd; logic [31:0] pd;
    bit sv; logic [4:0] srd; logic [31:0] sd;
    logic [4:0] q1; logic [4:0] q2;
    bit we; logic [4:0] wa; logic [31:0] wd;
    bit rdy; bit b1; bit b2; int cnt;
  } vec_t;

  function automatic vec_t mk(input int pv, input int prd, input logic [31:0] pd,
                              input int sv, input int srd, input logic [31:0] sd,
                              input int q1, input int q2,
                              input int e_we, input int e_wa, input logic [31:0] e_wd,
                              input int rdy, input int b1, input int b2, input int cnt);
    vec_t v;
    v.pv = pv[0]; v.prd = prd[4:0]; v.pd = pd;
    v.sv = sv[0]; v.srd = srd[4:0]; v.sd = sd;
    v.q1 = q1[4:0]; v.q2 = q2[4:0];
    v.we = e_we[0]; v.wa = e_wa[4:0]; v.wd = e_wd;
    v.rdy = rdy[0]; v.b1 = b1[0]; v.b2 = b2[0]; v.cnt = cnt;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // inputs                                  q1  q2  we wa  wd            rdy b1 b2 cnt
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0, 0, 0,             1, 0, 0, 0));
    vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      0, 0, 0, 0, 0,             1, 0, 0, 0));
    vt.push_back(mk(1, 0, 32'h1234,     0, 0, 0,      0, 0, 1, 5, 32'hDEADBEEF,  1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0, 5, 32'hDEADBEEF,  1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            1, 7, 32'h11, 7, 0, 0, 5, 32'hDEADBEEF,  1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 7, 0, 5, 32'hDEADBEEF,  1, 1, 1, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 0, 1, 7, 32'h11,        1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 0, 0, 7, 32'h11,        1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            1, 7, 32'h22, 7, 0, 0, 7, 32'h11,        1, 0, 0, 0));
    vt.push_back(mk(1, 3, 32'h33,       0, 0, 0,      7, 0, 0, 7, 32'h11,        1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 0, 1, 3, 32'h33,        1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 0, 1, 7, 32'h22,        1, 1, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      7, 0, 0, 7, 32'h22,        1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            1, 9, 32'hAA, 9, 0, 0, 7, 32'h22,        1, 0, 0, 0));
    vt.push_back(mk(1, 9, 32'hBB,       0, 0, 0,      9, 0, 0, 7, 32'h22,        1, 1, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      9, 0, 1, 9, 32'hBB,        1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      9, 0, 0, 9, 32'hAA,        1, 0, 0, 0));
    vt.push_back(mk(1, 12, 32'hC1,      1, 12, 32'hC2, 12, 0, 0, 9, 32'hAA,      1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      12, 0, 1, 12, 32'hC1,      1, 0, 0, 1));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      12, 12, 0, 12, 32'hC2,     1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            1, 0, 32'h55, 0, 0, 0, 12, 32'hC2,       1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0, 0, 12, 32'hC2,       1, 0, 0, 0));

    reset = 1'b1;
    p_valid = 0; p_rd = '0; p_data = '0;
    s_valid = 0; s_rd = '0; s_data = '0;
    q_a1 = '0; q_a2 = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    foreach (vt[i]) begin
      apply(vt[i].pv, vt[i].prd, vt[i].pd, vt[i].sv, vt[i].srd, vt[i].sd, vt[i].q1, vt[i].q2);
      check($sformatf("v%0d_we", i),         32'(we),         32'(vt[i].we));
      check($sformatf("v%0d_wa", i),         32'(wa),         32'(vt[i].wa));
      check($sformatf("v%0d_wd", i),         wd,              vt[i].wd);
      check($sformatf("v%0d_s_ready", i),    32'(s_ready),    32'(vt[i].rdy));
      check($sformatf("v%0d_busy1", i),      32'(busy1),      32'(vt[i].b1));
      check($sformatf("v%0d_busy2", i),      32'(busy2),      32'(vt[i].b2));
      check($sformatf("v%0d_fifo_count", i), 32'(fifo_count), 32'(vt[i].cnt));
      check($sformatf("v%0d_stall_req", i),  32'(stall_req),  32'd0);
      advance();
    end

    // Full FIFO under continuous primary traffic, starvation stall, then drain.
    for (int k = 0; k < 18; k++) begin
      apply(k < 12, 5'd1, 32'(32'h100 + k), k < 5, 5'(20 + k), 32'(32'hA0 + k), 5'd20, 5'd23);
      if (k == 4) begin
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd4);
      end
      if (k == 8)  check("stall_not_yet", 32'(stall_req), 32'd0);
      if (k == 9)  check("stall_asserted", 32'(stall_req), 32'd1);
      if (k == 12) check("stall_held", 32'(stall_req), 32'd1);
      if (k == 13) check("stall_released", 32'(stall_req), 32'd0);
      if (k >= 13 && k <= 16) begin
        check($sformatf("drain%0d_we", k - 13), 32'(we), 32'd1);
        check($sformatf("drain%0d_wa", k - 13), 32'(wa), 32'(20 + k - 13));
        check($sformatf("drain%0d_wd", k - 13), wd, 32'(32'hA0 + k - 13));
      end
      if (k == 17) check("drain_done_we", 32'(we), 32'd0);
      advance();
    end

    // Asynchronous reset with three entries queued.
    for (int k = 0; k < 4; k++) begin
      apply(1'b1, 5'd1, 32'(32'h200 + k), k < 3, 5'(14 + k), 32'(32'hB0 + k), 5'd14, 5'd15);
      advance();
    end
    p_valid = 0; s_valid = 0;
    #2;
    check("pre_reset_we", 32'(we), 32'd1);
    check("pre_reset_count", 32'(fifo_count), 32'd3);
    reset = 1'b1;
    #1;
    check("async_reset_we", 32'(we), 32'd0);
    check("async_reset_count", 32'(fifo_count), 32'd0);
    check("async_reset_busy1", 32'(busy1), 32'd0);
    #1;
    reset = 1'b0;
    model_reset();
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd14, 5'd16);
      check("post_reset_we", 32'(we), 32'd0);
      check("post_reset_count", 32'(fifo_count), 32'd0);
      advance();
    end

    // Randomized traffic, alternating light and heavy primary load.
    for (int c = 0; c < 400; c++) begin
      int pct;
      pct = ((c / 100) % 2 == 1) ? 85 : 35;
      apply($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom(),
            $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom(),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Initiator/writer side of the register-file write port.
- Merges two writeback sources onto the single write port (WE3/WA/WD):
  - the in-order pipeline writeback, which cannot stall;
  - a multi-cycle unit result stream (divider/load-miss) with valid/ready handshake.
- Buffers the secondary stream in a small FIFO.
- Tracks pending destination registers so decode can detect hazards.
- Raises a stall request when buffered results starve.

Parameters:
- DEPTH, 4, secondary FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, cycles FIFO head may wait before stall_req asserts (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- p_valid  in  1  pipeline writeback valid this cycle (always accepted)
- p_rd  in  5  pipeline destination register
- p_data  in  32  pipeline writeback data
- s_valid  in  1  secondary result valid
- s_ready  out  1  secondary accept (comb: FIFO not full)
- s_rd  in  5  secondary destination register
- s_data  in  32  secondary data
- we  out  1  register-file write enable (registered)
- wa  out  5  register-file write address (registered)
- wd  out  32  register-file write data (registered)
- q_a1, q_a2  in  5  decode source-register queries
- busy1, busy2  out  1  comb: queried reg has an undelivered secondary write
- stall_req  out  1  registered: pipeline must insert a bubble (p_valid=0) next cycle
- fifo_count  out  log2(DEPTH)+1  live FIFO occupancy

Behaviour:
- Reset (async) state:
  - FIFO empty; all entry live bits 0.
  - we=0, wa=0, wd=0, stall_req=0, starve counter=0.
  - s_ready=1 on the first cycle after release.
- Secondary accept: s_valid && s_ready at posedge.
  - s_rd!=0: enqueue {rd,data,live=1}.
  - s_rd==0: handshake completes but the result is discarded (no enqueue).
- Output stage, evaluated each cycle; result registered at posedge:
  - p_valid && p_rd!=0: we<=1, wa<=p_rd, wd<=p_data. Latency 1 cycle. Primary always wins.
  - Otherwise, if FIFO head present: pop head. we<=head.live, wa<=head.rd, wd<=head.data.
    - Dead entries pop with we<=0.
    - Min secondary latency: accept at N, we=1 during N+2.
  - Otherwise: we<=0; wa/wd hold their previous value.
  - p_valid with p_rd==0 is a no-write cycle, so the FIFO may drain.
- WAW squash:
  - When a primary write to rd R is selected, clear live on every FIFO entry with rd==R, including an entry enqueued the same cycle.
  - The newer pipeline value is never overwritten by an older secondary result.
- Scoreboard (combinational):
  - busyX=1 iff qX!=0 and any live FIFO entry has rd==qX.
  - busyX=1 also iff the output register holds a secondary write (we=1, source secondary) with wa==qX.
  - q=0 always gives busy=0.
- Full/empty:
  - s_ready=0 when count==DEPTH.
  - A pop in the same cycle does not raise s_ready; the ready decision is made on pre-pop count.
  - Simultaneous push+pop at count==DEPTH-1 keeps the count unchanged.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and the head is not popped.
  - Counter clears on pop or when the FIFO is empty.
  - stall_req<=1 when counter reaches STARVE_LIMIT-1 and the head is not popped this cycle.
  - stall_req deasserts the cycle after the head pops.
  - If the pipeline ignores stall_req, the block keeps primary priority and does not drop data.
- Pointers wrap modulo DEPTH; count covers 0..DEPTH.
- Reset mid-operation: all FIFO contents are lost and we drops to 0 immediately (asynchronous).

Test Plan:
- Reset then idle:
  - Release reset, no stimulus -> we=0, wa=0, wd=0, s_ready=1, stall_req=0, fifo_count=0, busy1=busy2=0.
- Primary only:
  - p_valid=1, p_rd=5, p_data=0xDEADBEEF at cycle N -> we=1, wa=5, wd=0xDEADBEEF in N+1.
  - p_rd=0 -> we=0.
- Secondary with conflict:
  - s_valid rd=7 data=0x11 at N, primary idle -> busy for q_a1=7 =1 from N+1 through N+2; we=1, wa=7, wd=0x11 in N+2; busy1=0 in N+3.
  - p_valid rd=3 at N+1 -> primary writes in N+2, secondary write delayed to N+3.
- WAW squash:
  - Enqueue rd=9 data=0xAA, then p_valid rd=9 data=0xBB on the next cycle.
  - Required: wd=0xBB written; entry pops with we=0; register 9 never receives 0xAA.
- Full FIFO:
  - Hold p_valid=1 rd=1 continuously; push 5 secondary results.
  - Required: first 4 accepted, s_ready=0 on the 5th, fifo_count=4.
  - stall_req=1 after 8 cycles of head waiting.
  - Drop p_valid -> head pops next cycle, stall_req=0 the cycle after, remaining entries drain one per cycle in order.
- Async reset mid-drain:
  - With 3 entries queued, pulse reset between edges -> we=0 immediately, fifo_count=0, no further writes after release.
